// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic light interface: light codes,
// phase encoding and the monitor's error vector.
package traffic_pkg;

  localparam logic [1:0] GREEN   = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] RED     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    P0 = 2'd0,  // A green,  B red
    P1 = 2'd1,  // A yellow, B red
    P2 = 2'd2,  // A red,    B green
    P3 = 2'd3   // A red,    B yellow
  } phase_t;

  typedef struct packed {
    logic pair;
    logic conflict;
    logic seq;
    logic yellow;
    logic sensor;
  } err_t;

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(2'(p + 2'd1));
  endfunction

  function automatic logic is_yellow(input phase_t p);
    return (p == P1) || (p == P3);
  endfunction

endpackage

// File: rtl/traffic_light_monitor_decoder.sv
// Combinational decode of the la/lb light pair into a phase, a legality flag
// and a conflict flag (no illegal code, yet neither road shows red).
module light_pair_decoder
  import traffic_pkg::*;
(
  input  logic [1:0] la,
  input  logic [1:0] lb,
  output phase_t     phase,
  output logic       valid,
  output logic       conflict
);

  always_comb begin
    phase = P0;
    valid = 1'b0;
    case ({la, lb})
      {GREEN,  RED   }: begin phase = P0; valid = 1'b1; end
      {YELLOW, RED   }: begin phase = P1; valid = 1'b1; end
      {RED,    GREEN }: begin phase = P2; valid = 1'b1; end
      {RED,    YELLOW}: begin phase = P3; valid = 1'b1; end
      default:          begin phase = P0; valid = 1'b0; end
    endcase
  end

  assign conflict = (la != ILLEGAL) && (lb != ILLEGAL) &&
                    (la != RED)     && (lb != RED);

endmodule

// File: rtl/traffic_light_monitor.sv
// Runtime safety checker for the traffic light controller: tracks phase,
// dwell and completed cycles, and flags illegal pairs, sequencing, yellow
// dwell and sensor-response violations with a sticky fault.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES = 1,
  parameter int DWELL_W       = 8,
  parameter int CNT_W         = 16,
  parameter bit CHECK_SENSORS = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         la,
  input  logic [1:0]         lb,
  input  logic               ta,
  input  logic               tb,
  output logic [1:0]         phase,
  output logic               phase_valid,
  output logic [DWELL_W-1:0] dwell,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               err_pair,
  output logic               err_conflict,
  output logic               err_seq,
  output logic               err_yellow,
  output logic               err_sensor,
  output logic               fault
);

  function automatic logic [DWELL_W-1:0] sat_inc(input logic [DWELL_W-1:0] d);
    return (&d) ? d : d + DWELL_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  // stage p0: decode of the incoming sample
  phase_t cur_phase_p0;
  logic   cur_vld_p0;
  logic   conflict_p0;

  light_pair_decoder u_dec (
    .la       (la),
    .lb       (lb),
    .phase    (cur_phase_p0),
    .valid    (cur_vld_p0),
    .conflict (conflict_p0)
  );

  // stage p1: registered sample state; vld_p1 doubles as the "previous sample valid" flag
  phase_t             phase_p1;
  logic               vld_p1;
  logic [DWELL_W-1:0] dwell_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic               ta_p1;
  logic               tb_p1;
  err_t               err_p1;
  logic               fault_p1;

  phase_t             phase_n;
  logic               vld_n;
  logic [DWELL_W-1:0] dwell_n;
  logic [CNT_W-1:0]   cnt_n;
  err_t               err_n;
  logic               fault_n;
  logic               dwell_at_yc;
  logic               dwell_below_yc;

  assign dwell_at_yc    = (int'(dwell_p1) == YELLOW_CYCLES);
  assign dwell_below_yc = (int'(dwell_p1) <  YELLOW_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_p1 <= P0;
      vld_p1   <= 1'b0;
      dwell_p1 <= '0;
      cnt_p1   <= '0;
      ta_p1    <= 1'b0;
      tb_p1    <= 1'b0;
      err_p1   <= '0;
      fault_p1 <= 1'b0;
    end else begin
      phase_p1 <= phase_n;
      vld_p1   <= vld_n;
      dwell_p1 <= dwell_n;
      cnt_p1   <= cnt_n;
      ta_p1    <= ta;
      tb_p1    <= tb;
      err_p1   <= err_n;
      fault_p1 <= fault_n;
    end
  end

  always_comb begin
    phase_n = phase_p1;
    vld_n   = 1'b0;
    dwell_n = '0;
    cnt_n   = cnt_p1;
    err_n   = '0;
    if (!cur_vld_p0) begin
      // invalid pair: phase holds, history is dropped so the next valid sample is a baseline
      err_n.pair     = 1'b1;
      err_n.conflict = conflict_p0;
    end else begin
      vld_n   = 1'b1;
      phase_n = cur_phase_p0;
      dwell_n = DWELL_W'(1);
      if (vld_p1) begin
        if (cur_phase_p0 == phase_p1) begin
          dwell_n      = sat_inc(dwell_p1);
          // flag only the sample that overstays, not every sample after it
          err_n.yellow = is_yellow(phase_p1) && dwell_at_yc;
          err_n.sensor = CHECK_SENSORS &&
                         (((phase_p1 == P0) && !ta_p1) ||
                          ((phase_p1 == P2) && !tb_p1));
        end else if (cur_phase_p0 == next_phase(phase_p1)) begin
          err_n.yellow = is_yellow(phase_p1) && dwell_below_yc;
          if (phase_p1 == P3) cnt_n = wrap_inc(cnt_p1);
        end else begin
          err_n.seq = 1'b1;
        end
      end
    end
    fault_n = fault_p1 | (|err_n);
  end

  always_comb begin
    phase        = phase_p1;
    phase_valid  = vld_p1;
    dwell        = dwell_p1;
    cycle_count  = cnt_p1;
    err_pair     = err_p1.pair;
    err_conflict = err_p1.conflict;
    err_seq      = err_p1.seq;
    err_yellow   = err_p1.yellow;
    err_sensor   = err_p1.sensor;
    fault        = fault_p1;
  end

endmodule
